square_wave_ctrl: RTL and testbench

Phase-accumulator sequencer for the square-wave lookup table in the wave generator. It owns the table's address and duty-select inputs, and steps a phase accumulator at a programmable tuning word. It applies new frequency and duty settings only at period boundaries, so the output is glitch-free, and it registers the table's sample onto a valid-qualified output stream with start/stop control.

---
 rtl/sq_wave_pkg.sv | 25 ++
 rtl/square_wave_ctrl_phase_accum.sv | 36 +++
 rtl/square_wave_ctrl.sv | 169 ++++++++++++++++
 tb/tb_square_wave_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_wave_pkg.sv
// Shared types and constants for the square-wave table sequencer.
package sq_wave_pkg;

  localparam int unsigned DEF_PHASE_W = 32;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned SEL_W       = 4;

  localparam logic [SEL_W-1:0] SEL_0PCT   = 4'd0;
  localparam logic [SEL_W-1:0] SEL_50PCT  = 4'd5;
  localparam logic [SEL_W-1:0] SEL_100PCT = 4'd10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  // Out-of-range duty codes collapse to 0% rather than aliasing.
  function automatic logic [SEL_W-1:0] legal_sel(input logic [SEL_W-1:0] sel,
                                                 input int unsigned sel_max);
    return (32'(sel) > sel_max) ? SEL_0PCT : sel;
  endfunction

endpackage

// File: rtl/square_wave_ctrl_phase_accum.sv
// Phase accumulator register; exposes the next-phase table address and carry-out.
module phase_accum
  import sq_wave_pkg::*;
#(
  parameter int unsigned PHASE_W = DEF_PHASE_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] tw,
  input  logic               clr,
  input  logic               en,
  output logic [ADDR_W-1:0]  addr_c,
  output logic               carry_c
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] sum_c;

  always_comb begin
    {carry_c, sum_c} = {1'b0, phase_q} + {1'b0, tw};
  end

  assign addr_c = sum_c[PHASE_W-1 -: ADDR_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (clr) begin
      phase_q <= '0;
    end else if (en) begin
      phase_q <= sum_c;
    end
  end

endmodule

// File: rtl/square_wave_ctrl.sv
// Square-wave table sequencer: boundary-synchronised config shadow, run/stop FSM, sample stream.
// Optional SQUARE_CTRL_PHASE_OFFSET_EN adds a per-config address offset input.
module square_wave_ctrl
  import sq_wave_pkg::*;
#(
  parameter int unsigned PHASE_W = DEF_PHASE_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SEL_MAX = 32'(SEL_100PCT)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [PHASE_W-1:0] i_cfg_tw,
  input  logic [SEL_W-1:0]   i_cfg_sel,
`ifdef SQUARE_CTRL_PHASE_OFFSET_EN
  input  logic [ADDR_W-1:0]  i_cfg_poff,
`endif
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_busy,
  output logic [ADDR_W-1:0]  o_lut_addr,
  output logic [SEL_W-1:0]   o_lut_sel,
  input  logic [DATA_W-1:0]  i_lut_data,
  output logic [DATA_W-1:0]  o_sample,
  output logic               o_sample_valid,
  output logic               o_wrap
);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] act_tw_q, sh_tw_q;
  logic [SEL_W-1:0]   act_sel_q, sh_sel_q;
  logic               sh_full_q, sh_full_d;
  logic               addr_vld_q;

  logic               busy_c, capture_c, apply_c, clr_c, carry_c;
  logic [ADDR_W-1:0]  raw_addr_c, addr_d;
  logic [SEL_W-1:0]   sel_upd_c, sel_d;
  logic               wrap_d, busy_d;

`ifdef SQUARE_CTRL_PHASE_OFFSET_EN
  logic [ADDR_W-1:0]  act_poff_q, sh_poff_q, poff_upd_c;
`endif

  assign busy_c    = (state_q != IDLE);
  assign capture_c = i_cfg_valid & ~sh_full_q;

  phase_accum #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W)
  ) u_accum (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .tw      (act_tw_q),
    .clr     (clr_c),
    .en      (busy_c),
    .addr_c  (raw_addr_c),
    .carry_c (carry_c)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, shadow hand-over and next output values.
  always_comb begin
    state_d   = state_q;
    apply_c   = 1'b0;
    clr_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_c   = 1'b1;
        apply_c = sh_full_q;
        if (i_start && !i_stop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        apply_c = sh_full_q & carry_c;
        if (i_stop) begin
          // A zero tuning word never carries, so there is no boundary to wait for.
          if (act_tw_q == '0) begin
            state_d = IDLE;
            clr_c   = 1'b1;
          end else begin
            state_d = STOP_PEND;
          end
        end
      end
      STOP_PEND: begin
        apply_c = sh_full_q & carry_c;
        if (carry_c) begin
          state_d = IDLE;
          clr_c   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr_c   = 1'b1;
      end
    endcase

    sh_full_d = capture_c ? 1'b1 : (apply_c ? 1'b0 : sh_full_q);
    sel_upd_c = apply_c ? sh_sel_q : act_sel_q;
`ifdef SQUARE_CTRL_PHASE_OFFSET_EN
    poff_upd_c = apply_c ? sh_poff_q : act_poff_q;
    addr_d     = busy_c ? ADDR_W'(raw_addr_c + poff_upd_c) : '0;
`else
    addr_d     = busy_c ? raw_addr_c : '0;
`endif
    sel_d     = busy_c ? sel_upd_c : '0;
    wrap_d    = busy_c & carry_c;
    busy_d    = (state_d != IDLE);
  end

  // Config shadow, active settings and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sh_full_q      <= 1'b0;
      sh_tw_q        <= '0;
      sh_sel_q       <= '0;
      act_tw_q       <= '0;
      act_sel_q      <= '0;
      addr_vld_q     <= 1'b0;
      o_cfg_ready    <= 1'b1;
      o_busy         <= 1'b0;
      o_lut_addr     <= '0;
      o_lut_sel      <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_wrap         <= 1'b0;
`ifdef SQUARE_CTRL_PHASE_OFFSET_EN
      sh_poff_q      <= '0;
      act_poff_q     <= '0;
`endif
    end else begin
      sh_full_q <= sh_full_d;
      if (capture_c) begin
        sh_tw_q  <= i_cfg_tw;
        sh_sel_q <= legal_sel(i_cfg_sel, SEL_MAX);
`ifdef SQUARE_CTRL_PHASE_OFFSET_EN
        sh_poff_q <= i_cfg_poff;
`endif
      end
      if (apply_c) begin
        act_tw_q  <= sh_tw_q;
        act_sel_q <= sh_sel_q;
`ifdef SQUARE_CTRL_PHASE_OFFSET_EN
        act_poff_q <= sh_poff_q;
`endif
      end
      addr_vld_q     <= busy_c;
      o_cfg_ready    <= ~sh_full_d;
      o_busy         <= busy_d;
      o_lut_addr     <= addr_d;
      o_lut_sel      <= sel_d;
      o_sample       <= i_lut_data;
      o_sample_valid <= addr_vld_q;
      o_wrap         <= wrap_d;
    end
  end

endmodule

// File: tb/tb_square_wave_ctrl.sv
// Bench for square_wave_ctrl: per-cycle behavioural model plus directed scenarios.
module tb_square_wave_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_tw = '0;
  logic [3:0]  cfg_sel = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy;
  logic [9:0]  lut_addr;
  logic [3:0]  lut_sel;
  logic [15:0] lut_data;
  logic [15:0] sample;
  logic        sample_valid;
  logic        wrap;
`ifdef SQUARE_CTRL_PHASE_OFFSET_EN
  logic [9:0]  cfg_poff = '0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  square_wave_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cfg_valid    (cfg_valid),
    .o_cfg_ready    (cfg_ready),
    .i_cfg_tw       (cfg_tw),
    .i_cfg_sel      (cfg_sel),
`ifdef SQUARE_CTRL_PHASE_OFFSET_EN
    .i_cfg_poff     (cfg_poff),
`endif
    .i_start        (start),
    .i_stop         (stop),
    .o_busy         (busy),
    .o_lut_addr     (lut_addr),
    .o_lut_sel      (lut_sel),
    .i_lut_data     (lut_data),
    .o_sample       (sample),
    .o_sample_valid (sample_valid),
    .o_wrap         (wrap)
  );

  // Table stand-in: duty level plus the address/select that produced it.
  function automatic logic [15:0] lut_fn(input logic [9:0] a, input logic [3:0] s);
    logic hi;
    hi = (int'(a) * 10 < int'(s) * 1024);
    return {hi, a, s, 1'b1};
  endfunction

  assign lut_data = lut_fn(lut_addr, lut_sel);

  task automatic chk(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic to_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL timeout %s @cyc %0d: got no event expected event", nm, cyc);
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 stopping at the next carry.
  localparam longint MOD = 64'h1_0000_0000;
  int     m_mode;
  longint m_ph, m_tw, m_ptw, sum, tw_old;
  int     m_sel, m_psel;
  bit     m_pend, m_live, run, carry, app, take, armed = 1'b0;
  logic        e_ready, e_busy, e_valid, e_wrap;
  logic [9:0]  e_addr;
  logic [3:0]  e_sel;
  logic [15:0] e_sample;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_ph = 0; m_tw = 0; m_sel = 0; m_pend = 0; m_ptw = 0; m_psel = 0;
      m_live = 0; e_ready = 1; e_busy = 0; e_addr = 0; e_sel = 0; e_sample = 0;
      e_valid = 0; e_wrap = 0; armed = 1;
    end else begin
      run    = (m_mode != 0);
      sum    = m_ph + m_tw;
      carry  = (sum >= MOD);
      sum    = sum % MOD;
      tw_old = m_tw;
      take   = cfg_valid && !m_pend;
      app    = m_pend && (!run || carry);
      e_sample = lut_fn(e_addr, e_sel);
      e_valid  = m_live;
      m_live   = run;
      e_wrap   = run && carry;
      if (app) begin
        m_tw = m_ptw; m_sel = m_psel; m_pend = 0;
      end
      if (take) begin
        m_pend = 1; m_ptw = longint'(cfg_tw); m_psel = (cfg_sel > 10) ? 0 : int'(cfg_sel);
      end
      e_addr = run ? 10'((sum >> 22) & 1023) : 10'd0;
      e_sel  = run ? 4'(m_sel) : 4'd0;
      case (m_mode)
        0: begin
          m_ph = 0;
          if (start && !stop) m_mode = 1;
        end
        1: begin
          if (stop && tw_old == 0) begin m_mode = 0; m_ph = 0; end
          else begin m_ph = sum; if (stop) m_mode = 2; end
        end
        default: begin
          if (carry) begin m_mode = 0; m_ph = 0; end
          else m_ph = sum;
        end
      endcase
      e_busy  = (m_mode != 0);
      e_ready = !m_pend;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("cfg_ready", cfg_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("lut_addr", lut_addr, e_addr);
      chk("lut_sel", lut_sel, e_sel);
      chk("sample", sample, e_sample);
      chk("sample_valid", sample_valid, e_valid);
      chk("wrap", wrap, e_wrap);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [31:0] tw, input logic [3:0] sel);
    int k;
    k = 0;
    while (!cfg_ready && k < 3000) begin @(negedge clk); k++; end
    if (!cfg_ready) to_fail("cfg_ready");
    cfg_valid = 1'b1; cfg_tw = tw; cfg_sel = sel;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_addr(input int a);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (int'(lut_addr) != a && k < 4000);
    if (int'(lut_addr) != a) to_fail("wait_addr");
  endtask

  task automatic wait_wrap();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!wrap && k < 4000);
    if (!wrap) to_fail("wait_wrap");
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 2000);
    if (busy) to_fail("wait_idle");
  endtask

  initial begin
    int n, nw;
    repeat (3) @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_addr", lut_addr, 0);
    chk("rst_valid", sample_valid, 0);
    rst_n = 1'b1;

    // 1: basic run at one address step per cycle
    cfg(32'h0040_0000, 4'd5);
    tick(3);
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_addr0", lut_addr, 0);
    chk("t1_valid0", sample_valid, 0);
    @(negedge clk);
    chk("t1_addr1", lut_addr, 1);
    chk("t1_valid1", sample_valid, 0);
    @(negedge clk);
    chk("t1_addr2", lut_addr, 2);
    chk("t1_valid2", sample_valid, 1);
    nw = 0;
    repeat (2048) begin @(negedge clk); if (wrap) nw++; end
    chk("t1_wraps", nw, 2);

    // 2: new settings take effect only at the boundary
    wait_addr(300);
    cfg(32'h0080_0000, 4'd3);
    chk("t2_ready_lo", cfg_ready, 0);
    chk("t2_sel_old", lut_sel, 5);
    wait_wrap();
    chk("t2_sel_new", lut_sel, 3);
    chk("t2_addr_wrap", lut_addr, 0);
    chk("t2_ready_hi", cfg_ready, 1);
    @(negedge clk);
    chk("t2_step2", lut_addr, 2);

    // 3: graceful stop completes the period
    cfg(32'h0040_0000, 4'd5);
    wait_wrap();
    wait_addr(100);
    pulse_stop();
    n = 0; nw = 0;
    if (sample_valid) n++;
    repeat (1100) begin
      @(negedge clk);
      if (sample_valid) n++;
      if (wrap) nw++;
    end
    chk("t3_valid_cnt", n, 925);
    chk("t3_wraps", nw, 1);
    chk("t3_busy", busy, 0);

    // 4: zero tuning word stops immediately
    cfg(32'h0, 4'd5);
    tick(3);
    pulse_start();
    tick(3);
    chk("t4_addr", lut_addr, 0);
    chk("t4_busy", busy, 1);
    pulse_stop();
    chk("t4_idle", busy, 0);
    chk("t4_nowrap", wrap, 0);

    // 5: illegal select and simultaneous start/stop
    cfg(32'h0040_0000, 4'd12);
    tick(3);
    pulse_start();
    tick(3);
    chk("t5_sel0", lut_sel, 0);
    chk("t5_busy", busy, 1);
    pulse_stop();
    wait_idle();
    tick(2);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t5_both", busy, 0);
    tick(2);
    chk("t5_both2", busy, 0);

    // 7: config captured together with start waits for the first boundary
    chk("t7_ready", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_tw = 32'h0080_0000; cfg_sel = 4'd5; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    chk("t7_busy", busy, 1);
    chk("t7_ready_lo", cfg_ready, 0);
    tick(2);
    chk("t7_addr_old", lut_addr, 2);
    chk("t7_sel_old", lut_sel, 0);
    wait_wrap();
    chk("t7_sel_new", lut_sel, 5);
    chk("t7_ready_hi", cfg_ready, 1);
    @(negedge clk);
    chk("t7_step2", lut_addr, 2);

    // 6: reset mid-run clears everything including the pending shadow
    cfg(32'h0100_0000, 4'd7);
    wait_addr(500);
    chk("t6_pending", cfg_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_ready", cfg_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_addr", lut_addr, 0);
    chk("t6_sel", lut_sel, 0);
    chk("t6_sample", sample, 0);
    chk("t6_valid", sample_valid, 0);
    chk("t6_wrap", wrap, 0);
    pulse_start();
    tick(3);
    chk("t6_run_addr", lut_addr, 0);
    chk("t6_run_sel", lut_sel, 0);
    pulse_stop();
    chk("t6_stop", busy, 0);
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
